sram_req_master: RTL and testbench

Initiator-side controller for the team's single-port byte-masked synchronous SRAM macro (cs/we/addr/data_in/mask in, registered data_out, 1-cycle read latency). It converts a valid/ready request channel from a core or bus bridge into SRAM strobes. Read data is captured into a 2-entry in-order response buffer with valid/ready backpressure. Writes are acknowledged through the same response channel, so upstream sees one uniform in-order transaction stream.

---
 rtl/sram_req_master.sv | 93 +++++++++
 tb/tb_sram_req_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_master.sv
// Request/response front end for the single-port byte-masked SRAM macro.
// Converts a valid/ready request stream into SRAM strobes and returns responses in order.
module sram_req_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MASK_WIDTH-1:0] req_mask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_we,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [MASK_WIDTH-1:0] sram_mask,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    logic                       pending;
    logic                       pending_we;
    logic [1:0]                 count;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 fifo_we;
    logic [1:0][DATA_WIDTH-1:0] fifo_data;

    logic       accept;
    logic       push;
    logic       pop;
    logic [2:0] credit;

    assign resp_valid = (count != 2'd0);
    assign pop        = resp_valid & resp_ready;
    assign push       = pending;

    // Outstanding work (buffered + in flight) less what drains this cycle must leave a free slot.
    assign credit    = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    assign req_ready = ~rst & (credit < 3'd2);
    assign accept    = req_valid & req_ready;

    assign sram_cs    = accept;
    assign sram_we    = accept & req_we;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;
    assign sram_mask  = (accept & req_we) ? req_mask : '0;

    assign resp_we    = fifo_we[rd_ptr];
    assign resp_rdata = fifo_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            pending_we <= 1'b0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_we    <= '0;
            fifo_data  <= '0;
        end else begin
            pending <= accept;
            if (accept) begin
                pending_we <= req_we;
            end
            // SRAM read register is only valid in the cycle right after the access.
            if (push) begin
                fifo_we[wr_ptr]   <= pending_we;
                fifo_data[wr_ptr] <= pending_we ? '0 : sram_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Credit check guarantees the buffer always has room for the in-flight response.
    always @(posedge clk) begin
        if (!rst && push) begin
            assert (count != 2'd2);
        end
    end

endmodule

// File: tb/tb_sram_req_master.sv
// Scoreboard bench for sram_req_master with a behavioural byte-masked SRAM model.
module tb_sram_req_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_mask;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_we;
    logic [DW-1:0] resp_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [MW-1:0] sram_mask;
    logic [DW-1:0] sram_rdata;

    sram_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
        .resp_rdata(resp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_mask(sram_mask), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro model: registered read data, byte-masked write.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int i = 0; i < MW; i++)
                    if (sram_mask[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < MW; i++)
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Monitor: sampled at the falling edge, mid-cycle.
    always @(negedge clk) begin
        int   outstanding;
        logic exp_pop, exp_ready, exp_cs, exp_valid;
        exp_t e;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_sram_cs", sram_cs, 0);
            chk("rst_resp_we", resp_we, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            sb.delete();
        end else begin
            outstanding = sb.size();
            exp_valid = (outstanding > 0) && (cyc - sb[0].cyc >= 2);
            exp_pop   = exp_valid & resp_ready;
            exp_ready = (outstanding - int'(exp_pop)) < 2;
            exp_cs    = req_valid & exp_ready;
            chk("resp_valid", resp_valid, exp_valid);
            chk("req_ready", req_ready, exp_ready);
            chk("sram_cs", sram_cs, exp_cs);
            chk("sram_we", sram_we, exp_cs & req_we);
            chk("sram_mask", sram_mask, (exp_cs & req_we) ? req_mask : '0);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_we", resp_we, e.we);
                    chk("resp_rdata", resp_rdata, e.data);
                end
            end
            if (req_valid && req_ready) begin
                chk("sram_addr", sram_addr, req_addr);
                if (req_we) chk("sram_wdata", sram_wdata, req_wdata);
                e.we  = req_we;
                e.cyc = cyc;
                e.data = req_we ? '0 : ref_mem[req_addr];
                if (req_we) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_mask);
                sb.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_mask = m;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int base;
        for (int i = 0; i < (1<<AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_rdata = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_mask = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read back
        send(1'b1, 10'h010, 32'hDEADBEEF, 4'b1111);
        send(1'b0, 10'h010, '0, '0);
        drain();

        // Partial mask write
        send(1'b1, 10'h010, 32'h11223344, 4'b0101);
        send(1'b0, 10'h010, '0, '0);
        drain();
        chk("ref_merge", ref_mem[10'h010], 32'hDE22BE44);

        // Preload and back-to-back reads
        for (int i = 0; i < 8; i++) send(1'b1, AW'(i), DW'(i * 3), 4'b1111);
        for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, '0);
        drain();

        // Backpressure stall
        resp_ready = 1'b0;
        base = acc_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h003; req_mask = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_accepts", acc_cnt - base, 2);
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        // Reset while a read is in flight
        send(1'b0, 10'h005, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 10'h010, '0, '0);
        drain();

        // Top address, write followed immediately by read
        send(1'b1, 10'h3FF, 32'hCAFEF00D, 4'b1111);
        send(1'b0, 10'h3FF, '0, '0);
        drain();
        chk("ref_top", ref_mem[10'h3FF], 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
